// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and sizing helpers for the PISO serializer (honours PISO_PARITY_EN)
package piso_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   // Bits needed to hold a down-counter that starts at the last frame index.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   // Bits per transmitted frame: data bits, plus one trailing parity bit when enabled.
   function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle of the PISO serializer
interface piso_serializer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             frame_start;
   logic             frame_last;

   modport master (
      output din, load_valid,
      input  load_ready, sout, sout_valid, frame_start, frame_last
   );

   modport slave (
      input  din, load_valid,
      output load_ready, sout, sout_valid, frame_start, frame_last
   );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with gapless back-to-back frames (optional PISO_PARITY_EN parity bit)
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   piso_serializer_if.slave  bus
);

   localparam int FRAME_LEN = frame_len(WIDTH);
   localparam int SR_W      = FRAME_LEN;
   localparam int CNT_W     = cnt_width(WIDTH);

   state_t            state_q, state_d;
   logic [SR_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start_q, start_d;

   logic              last_bit;
   logic              accept;
   logic [SR_W-1:0]   load_word;
   logic [SR_W-1:0]   shifted;

   // The bit on the wire is always the outgoing end of the shift register.
   assign last_bit        = (state_q == SHIFT) && (cnt_q == '0);
   assign bus.load_ready  = (state_q == IDLE) || last_bit;
   assign accept          = bus.load_valid && bus.load_ready;
   assign bus.sout_valid  = (state_q == SHIFT);
   assign bus.frame_last  = last_bit;
   assign bus.frame_start = start_q;
   assign bus.sout        = (state_q == SHIFT) &&
                            ((MSB_FIRST != 0) ? shreg_q[SR_W-1] : shreg_q[0]);

   // Captured frame image; the parity bit sits at the end that leaves last.
   always_comb begin
      load_word = '0;
`ifdef PISO_PARITY_EN
      if (MSB_FIRST != 0) load_word = {bus.din, ^bus.din};
      else                load_word = {^bus.din, bus.din};
`else
      load_word = bus.din;
`endif
   end

   // Advance the register by one bit toward the transmit end, filling with zero.
   always_comb begin
      shifted = '0;
      if (MSB_FIRST != 0) shifted = {shreg_q[SR_W-2:0], 1'b0};
      else                shifted = {1'b0, shreg_q[SR_W-1:1]};
   end

   // Next-state logic: load on accept, shift while in a frame, drop to IDLE after the last bit.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = load_word;
               cnt_d   = CNT_W'(FRAME_LEN - 1);
               start_d = 1'b1;
            end
         end
         SHIFT: begin
            if (accept) begin
               shreg_d = load_word;
               cnt_d   = CNT_W'(FRAME_LEN - 1);
               start_d = 1'b1;
            end else if (last_bit) begin
               state_d = IDLE;
               shreg_d = shifted;
            end else begin
               shreg_d = shifted;
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any frame in flight immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

endmodule
